// File: rtl/rf_scoreboard_if.sv
// Issue, lookup, result-broadcast and retire signals between the pipeline and the
// register-result scoreboard.
interface rf_scoreboard_if #(
   parameter int NRES = 2,
   parameter int TAGW = 4
);
   logic                       flush;
   logic                       iss_valid;
   logic [4:0]                 iss_addr;
   logic [1:0]                 iss_tnew;
   logic [TAGW-1:0]            iss_tag;
   logic [4:0]                 rs_addr;
   logic [4:0]                 rt_addr;
   logic [1:0]                 rs_tuse;
   logic [1:0]                 rt_tuse;
   logic                       iss_stall;
   logic                       rs_fwd_hit;
   logic                       rt_fwd_hit;
   logic [31:0]                rs_fwd_data;
   logic [31:0]                rt_fwd_data;
   logic [NRES-1:0]            res_valid;
   logic [NRES-1:0][4:0]       res_addr;
   logic [NRES-1:0][TAGW-1:0]  res_tag;
   logic [NRES-1:0][31:0]      res_data;
   logic                       wb_valid;
   logic [4:0]                 wb_addr;
   logic [TAGW-1:0]            wb_tag;

   modport master (
      output flush, iss_valid, iss_addr, iss_tnew, iss_tag,
             rs_addr, rt_addr, rs_tuse, rt_tuse,
             res_valid, res_addr, res_tag, res_data,
             wb_valid, wb_addr, wb_tag,
      input  iss_stall, rs_fwd_hit, rt_fwd_hit, rs_fwd_data, rt_fwd_data
   );

   modport slave (
      input  flush, iss_valid, iss_addr, iss_tnew, iss_tag,
             rs_addr, rt_addr, rs_tuse, rt_tuse,
             res_valid, res_addr, res_tag, res_data,
             wb_valid, wb_addr, wb_tag,
      output iss_stall, rs_fwd_hit, rt_fwd_hit, rs_fwd_data, rt_fwd_data
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-result scoreboard: tracks in-flight producers per register, captures
// broadcast results and serves forwarded operands or a stall to the issue stage.
module rf_scoreboard #(
   parameter int NRES = 2,
   parameter int TAGW = 4
) (
   input  logic           clk,
   input  logic           resetn,
   rf_scoreboard_if.slave sb
);
   // Entry 0 exists only for uniform indexing; nothing ever sets it busy.
   logic [31:0]            busy_q, busy_d;
   logic [31:0]            ready_q, ready_d;
   logic [31:0][1:0]       cnt_q, cnt_d;
   logic [31:0][TAGW-1:0]  tag_q, tag_d;
   logic [31:0][31:0]      data_q, data_d;

   logic [31:0]            cap_hit;
   logic [31:0][31:0]      cap_data;
   logic [1:0][4:0]        src_addr;
   logic [1:0][1:0]        src_tuse;
   logic [1:0]             src_hit;
   logic [1:0]             src_stall;
   logic [1:0][31:0]       src_data;
   logic                   stall;
   logic                   iss_acc;

   always_comb begin
      cap_hit  = '0;
      cap_data = '0;
      for (int i = 1; i < 32; i++) begin
         for (int k = 0; k < NRES; k++) begin
            if (sb.res_valid[k] && busy_q[i] && sb.res_addr[k] == 5'(i) &&
                sb.res_tag[k] == tag_q[i]) begin
               cap_hit[i]  = 1'b1;
               cap_data[i] = sb.res_data[k];
            end
         end
      end
   end

   // Lookups read pre-issue state, so an instruction never sees its own load.
   assign src_addr = {sb.rt_addr, sb.rs_addr};
   assign src_tuse = {sb.rt_tuse, sb.rs_tuse};

   always_comb begin
      src_hit   = '0;
      src_stall = '0;
      src_data  = '0;
      for (int s = 0; s < 2; s++) begin
         if (busy_q[src_addr[s]]) begin
            if (ready_q[src_addr[s]]) begin
               src_hit[s]  = 1'b1;
               src_data[s] = data_q[src_addr[s]];
            end else if (cap_hit[src_addr[s]]) begin
               src_hit[s]  = 1'b1;
               src_data[s] = cap_data[src_addr[s]];
            end else if (cnt_q[src_addr[s]] > src_tuse[s]) begin
               src_stall[s] = 1'b1;
            end
         end
      end
   end

   assign stall          = (|src_stall) & ~sb.flush;
   assign iss_acc        = sb.iss_valid & ~stall & ~sb.flush;
   assign sb.iss_stall   = stall;
   assign sb.rs_fwd_hit  = src_hit[0];
   assign sb.rt_fwd_hit  = src_hit[1];
   assign sb.rs_fwd_data = src_data[0];
   assign sb.rt_fwd_data = src_data[1];

   // Same-register priority: issue load, then result capture, then retire.
   always_comb begin
      busy_d  = busy_q;
      ready_d = ready_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      data_d  = data_q;
      for (int i = 1; i < 32; i++) begin
         if (sb.flush) begin
            busy_d[i]  = 1'b0;
            ready_d[i] = 1'b0;
            cnt_d[i]   = 2'd0;
         end else if (iss_acc && sb.iss_addr == 5'(i)) begin
            busy_d[i]  = 1'b1;
            ready_d[i] = 1'b0;
            cnt_d[i]   = sb.iss_tnew;
            tag_d[i]   = sb.iss_tag;
         end else begin
            if (busy_q[i] && cnt_q[i] != 2'd0) cnt_d[i] = cnt_q[i] - 2'd1;
            if (cap_hit[i]) begin
               data_d[i]  = cap_data[i];
               ready_d[i] = 1'b1;
               cnt_d[i]   = 2'd0;
            end
            if (sb.wb_valid && sb.wb_addr == 5'(i) && busy_q[i] && sb.wb_tag == tag_q[i])
               busy_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy_q  <= '0;
         ready_q <= '0;
         cnt_q   <= '0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-result scoreboard and operand bypass source for the in-order pipeline. It is the consumer end of the `wr_reg_info` (addr/data/Tnew) write path. It records each issued instruction's destination register and Tnew, captures results as functional units broadcast them, and answers issue-stage source-operand queries with forwarded data or a stall request. It sits beside the register file and the issue stage, and is flushed on exception or branch redirect.

## Interface
- Parameters:
- `NRES`, default 2: number of result broadcast ports.
- `TAGW`, default 4: width of the in-flight instruction tag.
- Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `flush`  in  1  invalidates every in-flight entry.
- `iss_valid`  in  1  issue stage presents an instruction.
- `iss_addr`  in  5  destination register; 0 means no write.
- `iss_tnew`  in  2  cycles until the result exists.
- `iss_tag`  in  TAGW  tag of the issuing instruction.
- `rs_addr`, `rt_addr`  in  5 each  source register numbers.
- `rs_tuse`, `rt_tuse`  in  2 each  cycles until the operand is consumed.
- `iss_stall`  out  1  issue must hold this cycle.
- `rs_fwd_hit`, `rt_fwd_hit`  out  1 each  forwarded data is valid.
- `rs_fwd_data`, `rt_fwd_data`  out  32 each  forwarded operand.
- `res_valid`  in  NRES  result broadcast valid, one bit per port.
- `res_addr`  in  NRES×5  destination register of each result.
- `res_tag`  in  NRES×TAGW  tag of each result.
- `res_data`  in  NRES×32  result value of each port.
- `wb_valid`  in  1  register file write has retired.
- `wb_addr`  in  5  register written at retirement.
- `wb_tag`  in  TAGW  tag of the retiring instruction.

## Operation
- Storage is one entry per register 1..31: `busy`, `ready`, `tag`, `cnt` (2b), `data` (32b). Register 0 has no entry. It is never busy and always reads as miss.
- Issue accept is `iss_valid & ~iss_stall & ~flush`. If `iss_addr` is not 0, the entry is loaded with busy=1, ready=0, cnt=`iss_tnew`, tag=`iss_tag`.
- Countdown: each cycle, every busy entry that is not being loaded this cycle decrements `cnt`, saturating at 0.
- Result capture: port k matches when `res_valid[k]` is set, the entry is busy, and `tag == res_tag[k]`. On a match the entry sets data=`res_data[k]`, ready=1, cnt=0.
  - A tag mismatch is ignored; the value belongs to an older, overwritten producer.
  - Tags are unique, so at most one port matches a given entry.
- Retire: `wb_valid` with a busy entry at `wb_addr` and a matching tag clears busy. A tag mismatch leaves the entry untouched.
- Same-register priority within one cycle: issue load > result capture > retire.
  - Result capture and retire with the same tag in one cycle leave the entry not busy.
- Source lookup is combinational, evaluated separately for rs and rt:
  - Register not busy → hit=0, data=0.
  - Busy and ready → hit=1, data=entry data.
  - Busy, not ready, and a result port matches this cycle → hit=1, data=`res_data` of that port. This is the same-cycle bypass.
  - Busy, not ready, no match, `cnt > tuse` → hit=0 and request a stall.
  - Busy, not ready, no match, `cnt <= tuse` → hit=0, no stall; a later pipeline stage forwards the value.
- `iss_stall` = stall_rs | stall_rt, gated to 0 while `flush` is asserted.
- The rs and rt lookups see the state before this cycle's issue load. An instruction never self-forwards.

## Timing
- Reset (`resetn`=0 at an edge): all busy, ready, cnt, tag and data fields clear.
  - Outputs in the reset state: `iss_stall`=0, hit=0, fwd_data=0.
  - Issue, result and retire inputs are ignored in the reset cycle.
- An issue load is visible to lookups from the next cycle.
- A captured result is visible as ready from the next cycle. In the capture cycle itself it is served through the bypass path.
- `flush`: all entries have busy=0 after the edge. An issue, result or retire in the same cycle is discarded. Lookups during the flush cycle use pre-flush state, but the stall is masked.
- Reset asserted mid-operation behaves as flush plus data clear. It overrides all other inputs.
- No combinational path from `iss_valid` to `iss_stall`.

## Test plan
- After reset, issue r5 with Tnew=2 and tag 3. The next cycle, query rs=r5 with Tuse=0 → `iss_stall`=1, hit=0. One cycle later cnt=1, still stalled. Send `res_valid`, r5, tag 3, 0xDEADBEEF → same cycle hit=1, data 0xDEADBEEF, stall=0.
- Issue r7 (tag 1), then r7 again (tag 2). A result for r7 with tag 1 is ignored: entry stays not ready. A result for r7 with tag 2 is captured.
- Query rt=r9 with Tuse=2 while r9 has cnt=1 and is not ready → stall=0, hit=0.
- Issue r3 and, in the same cycle, broadcast a result for r3 under the old tag and retire r3 under the old tag → the new entry is loaded (busy, not ready, new tag) and both older events are ignored.
- Entries r4 and r6 are busy. Assert `flush` together with `iss_valid` for r8 → the next cycle all three are not busy and the same-cycle stall is 0.
- Pulse `resetn` low while r10 is busy and ready → the next cycle a query of r10 gives hit=0, data=0, stall=0.
